// File: rtl/aes_hmac_frame_collector.sv
// aes_hmac_frame_collector
// Reassembles the byte-serial AES/HMAC result stream into parallel records.
// A frame is 16 cipher bytes, a short idle gap, then 32 tag bytes, each burst
// least-significant byte first. Completed frames are presented through a
// single holding register with a valid/ready handshake. The producer cannot
// be stalled, so malformed bursts are dropped with an error pulse, and frames
// that find the holding register full are dropped and flagged as overflow.
module aes_hmac_frame_collector #(
  parameter int MAX_GAP = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   i_data,
  input  logic         i_valid,
  input  logic         i_clr,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [127:0] o_cipher,
  output logic [255:0] o_tag,
  output logic         o_err,
  output logic         o_overflow
);

  localparam logic [1:0] S_CIPHER = 2'd0;
  localparam logic [1:0] S_GAP    = 2'd1;
  localparam logic [1:0] S_TAG    = 2'd2;

  // Gap counter must be able to hold MAX_GAP; one extra code keeps it safe.
  localparam int GW = $clog2(MAX_GAP + 2);

  logic [1:0]    state_reg, state_next;
  logic [4:0]    idx_reg, idx_next;
  logic [GW-1:0] gap_reg, gap_next;
  logic [127:0]  asm_cipher_reg, asm_cipher_next;
  logic [255:0]  asm_tag_reg, asm_tag_next;
  logic [127:0]  hold_cipher_reg, hold_cipher_next;
  logic [255:0]  hold_tag_reg, hold_tag_next;
  logic          hold_valid_reg, hold_valid_next;
  logic          err_reg, err_next;
  logic          ovf_reg, ovf_next;

  logic          byte_in;
  logic          cipher_we;
  logic          tag_we;
  logic          frame_done;
  logic          load;

  // A clear in the same cycle as a byte wins: the byte is simply ignored.
  assign byte_in   = i_valid & ~i_clr;
  assign cipher_we = byte_in && (state_reg == S_CIPHER);
  // In S_GAP idx is held at 0, so the first tag byte lands in lane 0.
  assign tag_we    = byte_in && ((state_reg == S_GAP) || (state_reg == S_TAG));

  // The final tag byte completes the frame on the same edge it is captured.
  assign frame_done = byte_in && (state_reg == S_TAG) && (idx_reg == 5'd31);
  // Holding register is free if empty or being emptied this very cycle.
  assign load       = frame_done && (!hold_valid_reg || i_ready);

  // Per-byte lane write enables for the assembly registers.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_cipher_lane
      assign asm_cipher_next[8*gi +: 8] =
        (cipher_we && (idx_reg == 5'(gi))) ? i_data : asm_cipher_reg[8*gi +: 8];
    end
    for (gi = 0; gi < 32; gi++) begin : g_tag_lane
      assign asm_tag_next[8*gi +: 8] =
        (tag_we && (idx_reg == 5'(gi))) ? i_data : asm_tag_reg[8*gi +: 8];
    end
  endgenerate

  // Burst framing FSM: byte index, gap timing and malformed-frame detection.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    gap_next   = gap_reg;
    err_next   = 1'b0;
    if (i_clr) begin
      state_next = S_CIPHER;
      idx_next   = 5'd0;
      gap_next   = '0;
    end else begin
      case (state_reg)
        S_CIPHER: begin
          if (i_valid) begin
            if (idx_reg == 5'd15) begin
              state_next = S_GAP;
              idx_next   = 5'd0;
              gap_next   = '0;
            end else begin
              idx_next = idx_reg + 5'd1;
            end
          end else if (idx_reg != 5'd0) begin
            // Cipher burst broke off early.
            err_next = 1'b1;
            idx_next = 5'd0;
          end
        end
        S_GAP: begin
          if (i_valid) begin
            state_next = S_TAG;
            idx_next   = 5'd1;
          end else if (gap_reg == GW'(MAX_GAP)) begin
            // This idle cycle would be one more than MAX_GAP allows.
            err_next   = 1'b1;
            state_next = S_CIPHER;
            idx_next   = 5'd0;
            gap_next   = '0;
          end else begin
            gap_next = gap_reg + 1'b1;
          end
        end
        S_TAG: begin
          if (i_valid) begin
            if (idx_reg == 5'd31) begin
              state_next = S_CIPHER;
              idx_next   = 5'd0;
            end else begin
              idx_next = idx_reg + 5'd1;
            end
          end else begin
            // Tag burst broke off early.
            err_next   = 1'b1;
            state_next = S_CIPHER;
            idx_next   = 5'd0;
          end
        end
        default: begin
          state_next = S_CIPHER;
          idx_next   = 5'd0;
          gap_next   = '0;
        end
      endcase
    end
  end

  // Holding register, output handshake and sticky overflow flag.
  always_comb begin
    hold_cipher_next = hold_cipher_reg;
    hold_tag_next    = hold_tag_reg;
    hold_valid_next  = hold_valid_reg;
    ovf_next         = ovf_reg;
    if (load) begin
      hold_cipher_next = asm_cipher_reg;
      // asm_tag_next already contains byte 31 captured this cycle.
      hold_tag_next    = asm_tag_next;
      hold_valid_next  = 1'b1;
    end else if (hold_valid_reg && i_ready) begin
      hold_valid_next = 1'b0;
    end
    if (i_clr) begin
      ovf_next = 1'b0;
    end else if (frame_done && !load) begin
      ovf_next = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_CIPHER;
      idx_reg         <= 5'd0;
      gap_reg         <= '0;
      asm_cipher_reg  <= '0;
      asm_tag_reg     <= '0;
      hold_cipher_reg <= '0;
      hold_tag_reg    <= '0;
      hold_valid_reg  <= 1'b0;
      err_reg         <= 1'b0;
      ovf_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      gap_reg         <= gap_next;
      asm_cipher_reg  <= asm_cipher_next;
      asm_tag_reg     <= asm_tag_next;
      hold_cipher_reg <= hold_cipher_next;
      hold_tag_reg    <= hold_tag_next;
      hold_valid_reg  <= hold_valid_next;
      err_reg         <= err_next;
      ovf_reg         <= ovf_next;
    end
  end

  assign o_valid    = hold_valid_reg;
  assign o_cipher   = hold_cipher_reg;
  assign o_tag      = hold_tag_reg;
  assign o_err      = err_reg;
  assign o_overflow = ovf_reg;

endmodule

// File: tb/tb_aes_hmac_frame_collector.sv
// tb_aes_hmac_frame_collector
// Directed scenarios for the frame collector with hand-computed records.
module tb_aes_hmac_frame_collector;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   i_data;
  logic         i_valid;
  logic         i_clr;
  logic         i_ready;
  logic         o_valid;
  logic [127:0] o_cipher;
  logic [255:0] o_tag;
  logic         o_err;
  logic         o_overflow;

  int n_cmp  = 0;
  int n_fail = 0;
  int err_cnt;
  int valid_cnt;

  // Frame A: cipher bytes 0x00..0x0F, tag bytes 0x20..0x3F.
  localparam logic [127:0] CIPH_A = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
  localparam logic [255:0] TAG_A  =
    256'h3f3e3d3c_3b3a3938_37363534_33323130_2f2e2d2c_2b2a2928_27262524_23222120;
  // Frame B: cipher bytes 0x40..0x4F, tag bytes 0x80..0x9F.
  localparam logic [127:0] CIPH_B = 128'h4f4e4d4c_4b4a4948_47464544_43424140;
  localparam logic [255:0] TAG_B  =
    256'h9f9e9d9c_9b9a9998_97969594_93929190_8f8e8d8c_8b8a8988_87868584_83828180;

  always #5 clk = ~clk;

  aes_hmac_frame_collector #(.MAX_GAP(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .i_clr      (i_clr),
    .i_ready    (i_ready),
    .o_valid    (o_valid),
    .o_cipher   (o_cipher),
    .o_tag      (o_tag),
    .o_err      (o_err),
    .o_overflow (o_overflow)
  );

  // One clock: drive inputs, take the edge, observe #1 later.
  task automatic step(input logic v, input logic [7:0] d);
    i_valid = v;
    i_data  = d;
    @(posedge clk);
    #1;
    if (o_err) err_cnt++;
    if (o_valid) valid_cnt++;
  endtask

  task automatic send_frame(input logic [7:0] cb, input logic [7:0] tb, input int gap);
    for (int k = 0; k < 16; k++) step(1'b1, cb + 8'(k));
    for (int g = 0; g < gap; g++) step(1'b0, 8'h00);
    for (int k = 0; k < 32; k++) step(1'b1, tb + 8'(k));
    $display("frame cipher_base=%02h tag_base=%02h gap=%0d sent: o_valid=%0b o_err_count=%0d",
             cb, tb, gap, o_valid, err_cnt);
  endtask

  task automatic test_reset();
    rst_n = 1'b1; i_valid = 1'b0; i_data = 8'h00; i_clr = 1'b0; i_ready = 1'b0;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b want=0", o_valid); end
    n_cmp++; if (o_cipher !== 128'h0) begin n_fail++; $display("FAIL reset_cipher got=%h want=0", o_cipher); end
    n_cmp++; if (o_tag !== 256'h0) begin n_fail++; $display("FAIL reset_tag got=%h want=0", o_tag); end
    n_cmp++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%0b want=0", o_err); end
    n_cmp++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%0b want=0", o_overflow); end
    rst_n = 1'b1;
    $display("reset: outputs checked");
  endtask

  task automatic test_basic();
    i_ready = 1'b1; err_cnt = 0; valid_cnt = 0;
    send_frame(8'h00, 8'h20, 1);
    n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got=%0b want=1", o_valid); end
    n_cmp++; if (valid_cnt != 1) begin n_fail++; $display("FAIL basic_valid_latency got=%0d want=1", valid_cnt); end
    n_cmp++; if (o_cipher !== CIPH_A) begin n_fail++; $display("FAIL basic_cipher got=%h want=%h", o_cipher, CIPH_A); end
    n_cmp++; if (o_tag !== TAG_A) begin n_fail++; $display("FAIL basic_tag got=%h want=%h", o_tag, TAG_A); end
    step(1'b0, 8'h00);
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_fall got=%0b want=0", o_valid); end
    n_cmp++; if (err_cnt != 0) begin n_fail++; $display("FAIL basic_err got=%0d want=0", err_cnt); end
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    i_ready = 1'b0; err_cnt = 0; valid_cnt = 0;
    send_frame(8'h00, 8'h20, 1);
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 8'h00);
      if (!(o_valid === 1'b1 && o_cipher === CIPH_A && o_tag === TAG_A)) bad++;
    end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold_stable got=%0d unstable cycles want=0", bad); end
    i_ready = 1'b1;
    step(1'b0, 8'h00);
    $display("backpressure: accept after 10 stalled cycles, o_valid=%0b", o_valid);
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_fall got=%0b want=0", o_valid); end
    n_cmp++; if (valid_cnt != 11) begin n_fail++; $display("FAIL bp_valid_cycles got=%0d want=11", valid_cnt); end
    n_cmp++; if (o_cipher !== CIPH_A) begin n_fail++; $display("FAIL bp_cipher_kept got=%h want=%h", o_cipher, CIPH_A); end
  endtask

  task automatic test_cipher_abort();
    i_ready = 1'b1; err_cnt = 0; valid_cnt = 0;
    for (int k = 0; k < 8; k++) step(1'b1, 8'(k));
    step(1'b0, 8'h00);
    n_cmp++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL abort_err_pulse got=%0b want=1", o_err); end
    step(1'b0, 8'h00);
    n_cmp++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL abort_err_width got=%0b want=0", o_err); end
    n_cmp++; if (err_cnt != 1) begin n_fail++; $display("FAIL abort_err_count got=%0d want=1", err_cnt); end
    n_cmp++; if (valid_cnt != 0) begin n_fail++; $display("FAIL abort_no_valid got=%0d want=0", valid_cnt); end
    send_frame(8'h40, 8'h80, 1);
    n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL abort_next_valid got=%0b want=1", o_valid); end
    n_cmp++; if (o_cipher !== CIPH_B) begin n_fail++; $display("FAIL abort_next_cipher got=%h want=%h", o_cipher, CIPH_B); end
    n_cmp++; if (o_tag !== TAG_B) begin n_fail++; $display("FAIL abort_next_tag got=%h want=%h", o_tag, TAG_B); end
    step(1'b0, 8'h00);
  endtask

  task automatic test_gap_max();
    i_ready = 1'b1; err_cnt = 0; valid_cnt = 0;
    send_frame(8'h00, 8'h20, 4);
    n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL gap4_valid got=%0b want=1", o_valid); end
    n_cmp++; if (o_tag !== TAG_A) begin n_fail++; $display("FAIL gap4_tag got=%h want=%h", o_tag, TAG_A); end
    n_cmp++; if (err_cnt != 0) begin n_fail++; $display("FAIL gap4_err got=%0d want=0", err_cnt); end
    step(1'b0, 8'h00);
  endtask

  task automatic test_gap_over();
    i_ready = 1'b1; err_cnt = 0; valid_cnt = 0;
    for (int k = 0; k < 16; k++) step(1'b1, 8'h40 + 8'(k));
    for (int g = 0; g < 5; g++) step(1'b0, 8'h00);
    $display("gap of 5 idle cycles: o_err=%0b", o_err);
    n_cmp++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL gap5_err_pulse got=%0b want=1", o_err); end
    step(1'b0, 8'h00);
    n_cmp++; if (err_cnt != 1) begin n_fail++; $display("FAIL gap5_err_count got=%0d want=1", err_cnt); end
    n_cmp++; if (valid_cnt != 0) begin n_fail++; $display("FAIL gap5_no_valid got=%0d want=0", valid_cnt); end
  endtask

  task automatic test_back_to_back();
    i_ready = 1'b0; err_cnt = 0; valid_cnt = 0;
    send_frame(8'h00, 8'h20, 1);
    send_frame(8'h40, 8'h80, 1);
    n_cmp++; if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL b2b_overflow got=%0b want=1", o_overflow); end
    n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid got=%0b want=1", o_valid); end
    n_cmp++; if (o_cipher !== CIPH_A) begin n_fail++; $display("FAIL b2b_cipher_kept got=%h want=%h", o_cipher, CIPH_A); end
    n_cmp++; if (o_tag !== TAG_A) begin n_fail++; $display("FAIL b2b_tag_kept got=%h want=%h", o_tag, TAG_A); end
    i_clr = 1'b1;
    step(1'b0, 8'h00);
    i_clr = 1'b0;
    $display("clear: o_overflow=%0b o_valid=%0b", o_overflow, o_valid);
    n_cmp++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL clr_overflow got=%0b want=0", o_overflow); end
    n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL clr_keeps_valid got=%0b want=1", o_valid); end
    i_ready = 1'b1;
    step(1'b0, 8'h00);
    // Clear mid-cipher together with a byte, then a zero-gap frame.
    for (int k = 0; k < 5; k++) step(1'b1, 8'hc0 + 8'(k));
    i_clr = 1'b1;
    step(1'b1, 8'haa);
    i_clr = 1'b0;
    send_frame(8'h40, 8'h80, 0);
    n_cmp++; if (o_cipher !== CIPH_B) begin n_fail++; $display("FAIL clr_next_cipher got=%h want=%h", o_cipher, CIPH_B); end
    n_cmp++; if (o_tag !== TAG_B) begin n_fail++; $display("FAIL clr_next_tag got=%h want=%h", o_tag, TAG_B); end
    n_cmp++; if (err_cnt != 0) begin n_fail++; $display("FAIL clr_no_err got=%0d want=0", err_cnt); end
    step(1'b0, 8'h00);
  endtask

  task automatic test_reset_midframe();
    i_ready = 1'b1; err_cnt = 0; valid_cnt = 0;
    for (int k = 0; k < 16; k++) step(1'b1, 8'(k));
    step(1'b0, 8'h00);
    for (int k = 0; k < 20; k++) step(1'b1, 8'h20 + 8'(k));
    i_valid = 1'b1; i_data = 8'h34;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (o_cipher !== 128'h0) begin n_fail++; $display("FAIL midrst_cipher got=%h want=0", o_cipher); end
    n_cmp++; if (o_tag !== 256'h0) begin n_fail++; $display("FAIL midrst_tag got=%h want=0", o_tag); end
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got=%0b want=0", o_valid); end
    n_cmp++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL midrst_overflow got=%0b want=0", o_overflow); end
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    rst_n = 1'b1;
    $display("reset during tag byte 20 released");
    send_frame(8'h40, 8'h80, 1);
    n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_next_valid got=%0b want=1", o_valid); end
    n_cmp++; if (o_cipher !== CIPH_B) begin n_fail++; $display("FAIL midrst_next_cipher got=%h want=%h", o_cipher, CIPH_B); end
    n_cmp++; if (o_tag !== TAG_B) begin n_fail++; $display("FAIL midrst_next_tag got=%h want=%h", o_tag, TAG_B); end
    n_cmp++; if (err_cnt != 0) begin n_fail++; $display("FAIL midrst_no_err got=%0d want=0", err_cnt); end
    step(1'b0, 8'h00);
  endtask

  initial begin
    err_cnt = 0;
    valid_cnt = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_cipher_abort();
    test_gap_max();
    test_gap_over();
    test_back_to_back();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_hmac_frame_collector.md
Name: aes_hmac_frame_collector

Overview:
- Downstream of the AES/PBKDF2/HMAC top. Consumes its byte-serial output (o_data/o_valid) and reassembles each result frame.
- A frame is a 16-byte AES cipher burst, a short gap, then a 32-byte HMAC tag burst.
- Presents each complete frame as one parallel record with a valid/ready handshake.
- Detects malformed bursts and overflow, because the upstream producer cannot be stalled.

Parameters:
- MAX_GAP, 4: maximum number of consecutive idle cycles allowed between cipher byte 15 and tag byte 0 (upstream nominal gap is 1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_data  in  8  byte from upstream o_data
- i_valid  in  1  byte strobe from upstream o_valid
- i_clr  in  1  synchronous clear: aborts the partial frame and clears o_overflow
- i_ready  in  1  consumer accepts the record when o_valid=1
- o_valid  out  1  record available
- o_cipher  out  128  assembled AES cipher
- o_tag  out  256  assembled HMAC tag
- o_err  out  1  one-cycle pulse when a malformed frame is dropped
- o_overflow  out  1  sticky; set when a completed frame is lost because the holding register is full

Behaviour:
- Clocking and reset:
  - Single clock.
  - Reset is asynchronous and active-low; while rst_n=0 all outputs and all internal registers are 0 and the state is S_CIPHER with idx=0.
  - Reset asserted mid-frame discards the partial frame without an error pulse.
- Byte order:
  - Each burst arrives least-significant byte first.
  - Cipher byte k (k=0..15) is stored in cipher[8k+7:8k].
  - Tag byte k (k=0..31) is stored in tag[8k+7:8k].
- Internal state:
  - Assembly registers: asm_cipher, asm_tag.
  - idx: 5-bit byte index. gap_cnt: gap counter.
  - Holding register drives o_cipher/o_tag/o_valid.
- FSM:
  - S_CIPHER:
    - i_valid=1: store the byte at idx, idx++.
    - Byte 15 stored: go to S_GAP, gap_cnt=0.
    - i_valid=0 with idx in 1..15: o_err pulse, idx=0, stay in S_CIPHER.
    - i_valid=0 with idx=0: idle, no action.
  - S_GAP:
    - i_valid=0: gap_cnt++. If gap_cnt would exceed MAX_GAP (MAX_GAP+1 idle cycles): o_err, go to S_CIPHER, idx=0.
    - i_valid=1, including a zero-cycle gap: store tag byte 0, idx=1, go to S_TAG.
  - S_TAG:
    - i_valid=1: store the byte at idx, idx++.
    - i_valid=0 before byte 31: o_err, go to S_CIPHER, idx=0.
    - Byte 31 stored: frame complete, go to S_CIPHER, idx=0.
- Frame completion:
  - If the holding register is empty, or o_valid&i_ready in the same cycle, load the holding register; o_valid=1 on the next cycle.
  - Otherwise drop the frame and set o_overflow; the held record is unchanged.
- Output handshake:
  - Latency: o_valid rises the cycle after the edge that captures tag byte 31.
  - o_valid stays high and o_cipher/o_tag stay stable until the cycle with o_valid&i_ready; o_valid then falls unless a new frame loads in that same cycle.
  - o_cipher/o_tag keep their last values after o_valid falls.
- i_clr:
  - Same cycle as i_valid: i_clr wins; the byte is discarded.
  - Resets the FSM to S_CIPHER with idx=0 and clears o_overflow.
  - Does not touch the holding register or o_valid.
  - Produces no o_err.
- Errors:
  - o_err is high for exactly one cycle per dropped malformed frame.
  - A new cipher burst may start the cycle after an error, or immediately after completion with no idle cycle.

Test Plan:
- Reset, then 16 bytes 0x00..0x0F, 1 idle cycle, 32 bytes 0x20..0x3F, i_ready=1:
  - o_valid pulses 1 cycle after byte 0x3F.
  - o_cipher=0x0F0E..0100; o_tag=0x3F3E..2120.
  - o_err=0.
- Same frame with i_ready=0 for 10 cycles, then i_ready=1:
  - o_valid held for 11 cycles with stable data; deasserts after the accept.
- i_valid drops after cipher byte 7:
  - o_err=1 for one cycle; no o_valid.
  - The next clean frame assembles correctly.
- Gap of MAX_GAP=4 idle cycles:
  - Frame accepted.
- Gap of 5 idle cycles:
  - o_err pulse, frame dropped.
- Two back-to-back clean frames with i_ready=0 throughout:
  - First frame held; o_overflow=1 after the second completes; o_cipher still equals frame 1.
  - i_clr clears o_overflow.
- rst_n pulsed low during tag byte 20, then a clean frame:
  - All outputs are 0 during reset; no o_err.
  - The clean frame is received correctly.
